// File: rtl/char_buffer_pkg.sv
// Shared constants, state encoding and glyph generator for the character text buffer.
package char_buffer_pkg;

  localparam int GRID_COLS = 16;
  localparam int GRID_ROWS = 16;
  localparam int FONT_ROWS = 16;

  localparam logic [7:0] CODE_BS   = 8'h08;
  localparam logic [7:0] CODE_LF   = 8'h0A;
  localparam logic [7:0] CODE_FF   = 8'h0C;
  localparam logic [7:0] CODE_CR   = 8'h0D;
  localparam logic [7:0] PRINT_MIN = 8'h20;
  localparam logic [7:0] PRINT_MAX = 8'h7E;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } buf_state_t;

  // Glyph row generator standing in for the 8x16 font table; space is always empty.
  function automatic logic [7:0] font_row(input logic [6:0] code, input logic [3:0] line);
    if (code == 7'h20) return 8'h00;
    return {code, 1'b1} ^ {line, line};
  endfunction

endpackage

// File: rtl/char_text_buffer_font_rom.sv
// 8x16 font ROM: 11-bit {code, line} address, one registered pixel row per cycle.
module font_rom
  import char_buffer_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic [10:0] addr,
  output logic [7:0]  data
);

  logic [7:0] data_reg;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      data_reg <= '0;
    end else begin
      data_reg <= font_row(addr[10:4], addr[3:0]);
    end
  end

  assign data = data_reg;

endmodule

// File: rtl/char_text_buffer.sv
// 16x16 character buffer: byte-stream writer with cursor control and a 2-cycle font lookup path.
module char_text_buffer
  import char_buffer_pkg::*;
#(
  parameter logic [6:0] BLANK_CODE = 7'h20,
  parameter bit         INIT_CLEAR = 1'b1
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic [7:0] char_xy,
  input  logic [3:0] char_line,
  output logic [7:0] char_pixels,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic [3:0] cursor_x,
  output logic [3:0] cursor_y,
  output logic       busy
);

  logic [6:0] char_ram [GRID_COLS*GRID_ROWS];

  buf_state_t state_reg, state_next;
  logic [7:0] clr_addr_reg, clr_addr_next;
  logic [3:0] cursor_x_reg, cursor_x_next;
  logic [3:0] cursor_y_reg, cursor_y_next;
  logic       wr_ready_reg, busy_reg;
  logic       accept;
  logic       ram_we;
  logic [7:0] ram_waddr;
  logic [6:0] ram_wdata;
  logic [6:0] code_reg;
  logic [3:0] line_reg;

  assign accept = wr_valid && wr_ready_reg && (state_reg == ST_IDLE);

  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    cursor_x_next = cursor_x_reg;
    cursor_y_next = cursor_y_reg;
    ram_we        = 1'b0;
    ram_waddr     = clr_addr_reg;
    ram_wdata     = BLANK_CODE;
    case (state_reg)
      ST_CLEAR: begin
        ram_we        = 1'b1;
        clr_addr_next = clr_addr_reg + 8'd1;
        if (clr_addr_reg == 8'hFF) begin
          state_next    = ST_IDLE;
          cursor_x_next = 4'd0;
          cursor_y_next = 4'd0;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          if (wr_data >= PRINT_MIN && wr_data <= PRINT_MAX) begin
            ram_we        = 1'b1;
            ram_waddr     = {cursor_y_reg, cursor_x_reg};
            ram_wdata     = wr_data[6:0];
            cursor_x_next = cursor_x_reg + 4'd1;
            if (cursor_x_reg == 4'hF) cursor_y_next = cursor_y_reg + 4'd1;
          end else begin
            case (wr_data)
              CODE_CR: cursor_x_next = 4'd0;
              CODE_LF: cursor_y_next = cursor_y_reg + 4'd1;
              CODE_BS: begin
                if (cursor_x_reg != 4'd0) begin
                  cursor_x_next = cursor_x_reg - 4'd1;
                  ram_we        = 1'b1;
                  ram_waddr     = {cursor_y_reg, cursor_x_reg - 4'd1};
                end
              end
              CODE_FF: begin
                state_next    = ST_CLEAR;
                clr_addr_next = 8'd0;
              end
              default: ;
            endcase
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake and busy flags are registered from the next state so they flip with it.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= INIT_CLEAR ? ST_CLEAR : ST_IDLE;
      clr_addr_reg <= 8'd0;
      cursor_x_reg <= 4'd0;
      cursor_y_reg <= 4'd0;
      wr_ready_reg <= 1'b0;
      busy_reg     <= INIT_CLEAR;
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
      cursor_x_reg <= cursor_x_next;
      cursor_y_reg <= cursor_y_next;
      wr_ready_reg <= (state_next == ST_IDLE);
      busy_reg     <= (state_next == ST_CLEAR);
    end
  end

  always_ff @(posedge clk_in) begin
    if (ram_we) char_ram[ram_waddr] <= ram_wdata;
  end

  // Read-first: a same-cycle write to the looked-up cell returns the previous code.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      code_reg <= '0;
      line_reg <= '0;
    end else begin
      code_reg <= char_ram[char_xy];
      line_reg <= char_line;
    end
  end

  font_rom u_font_rom (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .addr   ({code_reg, line_reg}),
    .data   (char_pixels)
  );

  assign wr_ready = wr_ready_reg;
  assign busy     = busy_reg;
  assign cursor_x = cursor_x_reg;
  assign cursor_y = cursor_y_reg;

endmodule
